// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: merges load-use, MEM wait and MUL/DIV
// sequencer requests into the per-stage stall bus.
module pipe_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stallreq_id,
    input  logic       stallreq_mem,
    input  logic       ex_mc_start,
    input  logic       ex_mc_kind,
    output logic [5:0] stall,
    output logic       mc_busy,
    output logic       mc_done
);

    localparam logic [5:0] MASK_MEM = 6'b011111;
    localparam logic [5:0] MASK_MC  = 6'b001111;
    localparam logic [5:0] MASK_ID  = 6'b000111;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        MC_RUN,
        MC_DONE
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] cnt_q;
    logic [5:0] cnt_d;
    logic       mc_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The hold mask covers the accept cycle plus all of MC_RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mc_hold = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ex_mc_start && !stallreq_mem) begin
                    mc_hold = 1'b1;
                    state_d = MC_RUN;
                    cnt_d   = ex_mc_kind ? DIV_LOAD : MUL_LOAD;
                end
            end
            MC_RUN: begin
                mc_hold = 1'b1;
                if (cnt_q == 6'd1) begin
                    state_d = MC_DONE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            MC_DONE: begin
                if (!stallreq_mem) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        stall = 6'b000000;
        if (!rst) begin
            if (stallreq_mem) stall = stall | MASK_MEM;
            if (mc_hold)      stall = stall | MASK_MC;
            if (stallreq_id)  stall = stall | MASK_ID;
        end
    end

    assign mc_busy = (state_q == MC_RUN);
    assign mc_done = (state_q == MC_DONE);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed test-plan scenarios plus random traffic,
// all checked every cycle against a window-based reference model.
module tb_pipe_ctrl;

    localparam int MUL = 4;
    localparam int DIV = 33;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id = 1'b0;
    logic       mem = 1'b0;
    logic       start = 1'b0;
    logic       kind = 1'b0;
    logic [5:0] stall;
    logic       mc_busy;
    logic       mc_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .MUL_CYCLES(MUL),
        .DIV_CYCLES(DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (id),
        .stallreq_mem(mem),
        .ex_mc_start (start),
        .ex_mc_kind  (kind),
        .stall       (stall),
        .mc_busy     (mc_busy),
        .mc_done     (mc_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, return at the falling edge of that cycle.
    task automatic drive(input bit r, input bit i, input bit m,
                         input bit s, input bit k);
        @(posedge clk);
        #1;
        rst = r; id = i; mem = m; start = s; kind = k;
        @(negedge clk);
    endtask

    // Reference model: an accepted op at cycle t with latency L holds
    // cycles t..t+L-1, is busy t+1..t+L-1 and is done from t+L until
    // the first cycle without a MEM wait.
    int         m_acc = -1;
    int         m_lat = 0;
    int         m_cyc = 0;
    bit         m_valid = 1'b0;
    bit         m_act;
    bit         m_mask;
    bit         m_busy;
    bit         m_done;
    logic [5:0] m_stall;

    always @(negedge clk) begin
        if (m_valid) begin
            m_act = (m_acc >= 0);
            if (!m_act && !rst && start && !mem) begin
                m_acc = m_cyc;
                m_lat = kind ? DIV : MUL;
                m_act = 1'b1;
            end
            m_mask = m_act && (m_cyc < m_acc + m_lat);
            m_busy = m_act && (m_cyc > m_acc) && (m_cyc < m_acc + m_lat);
            m_done = m_act && (m_cyc >= m_acc + m_lat);
            m_stall = 6'b000000;
            if (!rst) begin
                if (mem)    m_stall = m_stall | 6'b011111;
                if (m_mask) m_stall = m_stall | 6'b001111;
                if (id)     m_stall = m_stall | 6'b000111;
            end
            chk("model_stall", int'(stall), int'(m_stall));
            chk("model_busy", int'(mc_busy), int'(m_busy));
            chk("model_done", int'(mc_done), int'(m_done));
            if (rst || (m_done && !mem)) m_acc = -1;
        end else if (rst) begin
            chk("model_rst_stall", int'(stall), 0);
            m_acc = -1;
            m_valid = 1'b1;
        end
        m_cyc++;
    end

    bit mm;

    initial begin
        // Reset with every request high.
        drive(1, 1, 1, 1, 1);
        chk("rst_stall0", int'(stall), 0);
        drive(1, 1, 1, 1, 1);
        chk("rst_stall1", int'(stall), 0);
        chk("rst_busy", int'(mc_busy), 0);
        chk("rst_done", int'(mc_done), 0);
        drive(0, 0, 0, 0, 0);
        chk("rel_stall", int'(stall), 0);
        chk("rel_busy", int'(mc_busy), 0);

        // Single-source masks.
        drive(0, 1, 0, 0, 0);
        chk("id_mask", int'(stall), 'h07);
        drive(0, 0, 1, 0, 0);
        chk("mem_mask", int'(stall), 'h1F);
        drive(0, 0, 0, 0, 0);
        chk("no_mask", int'(stall), 0);

        // MUL with default latency.
        for (int k = 0; k <= 4; k++) begin
            drive(0, 0, 0, 1, 0);
            chk("mul_stall", int'(stall), (k < 4) ? 'h0F : 0);
            chk("mul_busy", int'(mc_busy), (k >= 1 && k <= 3) ? 1 : 0);
            chk("mul_done", int'(mc_done), (k == 4) ? 1 : 0);
        end
        drive(0, 0, 0, 0, 0);
        chk("mul_after", int'(mc_done), 0);

        // DIV with MEM waits inside the run and at the done cycle.
        for (int k = 0; k <= 35; k++) begin
            mm = (k >= 5 && k <= 7) || (k >= 33 && k <= 34);
            drive(0, 0, mm, 1, 1);
            if (k <= 32)
                chk("div_stall", int'(stall), mm ? 'h1F : 'h0F);
            else
                chk("div_stall_d", int'(stall), mm ? 'h1F : 0);
            chk("div_done", int'(mc_done), (k >= 33) ? 1 : 0);
        end
        drive(0, 0, 0, 0, 0);
        chk("div_idle_done", int'(mc_done), 0);
        chk("div_idle_busy", int'(mc_busy), 0);
        chk("div_idle_stall", int'(stall), 0);

        // Start blocked by MEM for two cycles.
        for (int k = 0; k <= 6; k++) begin
            drive(0, 0, (k < 2), 1, 0);
            if (k < 2)      chk("blk_stall", int'(stall), 'h1F);
            else if (k < 6) chk("blk_stall", int'(stall), 'h0F);
            else            chk("blk_stall", int'(stall), 0);
            chk("blk_busy", int'(mc_busy), (k >= 3 && k <= 5) ? 1 : 0);
            chk("blk_done", int'(mc_done), (k == 6) ? 1 : 0);
        end
        drive(0, 0, 0, 0, 0);

        // Reset in the middle of a DIV.
        for (int k = 0; k < 10; k++) drive(0, 0, 0, 1, 1);
        chk("rdiv_busy_pre", int'(mc_busy), 1);
        drive(1, 0, 0, 1, 1);
        chk("rdiv_rst_stall", int'(stall), 0);
        for (int k = 0; k < 40; k++) begin
            drive(0, 0, 0, 0, 0);
            chk("rdiv_stall", int'(stall), 0);
            chk("rdiv_busy", int'(mc_busy), 0);
            chk("rdiv_done", int'(mc_done), 0);
        end

        // Random traffic, checked by the model only.
        for (int n = 0; n < 4000; n++) begin
            drive($urandom_range(0, 149) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) != 0,
                  $urandom_range(0, 2) == 0);
        end
        drive(0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall controller for the five-stage core. It merges the ID load-use request, the MEM data-SRAM wait request and a multi-cycle MUL/DIV sequencer into the 6-bit `stall` bus consumed by every pipeline register, PC through WB. It also times the EX multi-cycle operation and raises `mc_done` when the EX result may advance into EX/MEM.

## Interface
- `MUL_CYCLES`, default 4: EX cycles a MUL occupies; legal range 2..63.
- `DIV_CYCLES`, default 33: EX cycles a DIV occupies; legal range 2..63.
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stallreq_id`  in  1: load-use hazard detected in ID.
- `stallreq_mem`  in  1: data SRAM not ready in MEM.
- `ex_mc_start`  in  1: EX holds a multi-cycle op. Level signal; it stays high while the instruction sits in EX.
- `ex_mc_kind`  in  1: 0 = MUL, 1 = DIV; valid with `ex_mc_start`.
- `stall`  out  6 (`StallBus`): [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB, [5]=WB; `Stop`=1.
- `mc_busy`  out  1: sequencer in MC_RUN.
- `mc_done`  out  1: EX multi-cycle result is valid this cycle.

## Operation
- Stall masks:
  - `stallreq_mem` gives 6'b011111.
  - Multi-cycle hold gives 6'b001111.
  - `stallreq_id` gives 6'b000111.
- `stall` is the bitwise OR of all active masks, so the deepest request wins. Downstream registers insert a bubble wherever `stall[i]`=Stop and `stall[i+1]`=NoStop.
- `stall` is combinational from the inputs and sequencer state. Requests act in the same cycle.
- Sequencer states:
  - **IDLE**: `mc_busy`=0, `mc_done`=0. The start is accepted only when `ex_mc_start`=1 and `stallreq_mem`=0.
    - On acceptance, the multi-cycle mask is asserted that same cycle.
    - The 6-bit counter `cnt` loads LAT-1, where LAT = `DIV_CYCLES` if `ex_mc_kind`=1, else `MUL_CYCLES`.
    - Next state is MC_RUN.
  - **MC_RUN**: multi-cycle mask asserted, `mc_busy`=1.
    - Each cycle: if `cnt`==1, go to MC_DONE; otherwise decrement `cnt`.
    - `stallreq_mem` does not pause counting.
  - **MC_DONE**: `mc_done`=1 and the multi-cycle mask is released.
    - If `stallreq_mem`=0, return to IDLE. EX/MEM captures the result this cycle.
    - If `stallreq_mem`=1, stay in MC_DONE with `mc_done` held high until MEM clears.
- While in MC_RUN or MC_DONE, `ex_mc_start` is ignored because it is the same instruction still held in EX. No re-accept happens in the cycle the sequencer leaves MC_DONE.
- `stallreq_id` during MC_RUN is harmless; its mask is a subset of the multi-cycle mask.

## Timing
- Start accepted at cycle t:
  - Multi-cycle mask high in cycles t..t+LAT-1, exactly LAT cycles.
  - `mc_done` high at t+LAT.
- MC_RUN lasts LAT-1 cycles (t+1..t+LAT-1).
- If `stallreq_mem`=1 at t, the start is not accepted. Acceptance happens in the first cycle with `stallreq_mem`=0, and t is measured from that cycle.
- Reset values: state IDLE, `cnt`=0, `mc_busy`=0, `mc_done`=0.
- `stall` is forced to 6'b000000 while `rst`=1.
- Reset mid-operation abandons the op immediately. The next cycle after `rst` falls is IDLE with no stall.
- A second start needs `ex_mc_start` to be observed high in IDLE. Back-to-back multi-cycle ops are therefore separated by at least the MC_DONE→IDLE transition.

## Test plan
- **Reset:** assert `rst` 2 cycles with all requests high. Required: `stall`=000000, `mc_busy`=0, `mc_done`=0; at release, the state is IDLE.
- **Single-source masks:** pulse `stallreq_id` 1 cycle, then `stallreq_mem` 1 cycle. Required: `stall`=000111, then 011111, same cycle as each request; 000000 otherwise.
- **MUL default:** `ex_mc_start`=1, kind=0 from cycle 10 until `mc_done`. Required:
  - `stall`=001111 in cycles 10..13.
  - `mc_busy`=1 in cycles 11..13.
  - `mc_done`=1 in cycle 14 only, with `stall`=000000.
- **DIV with MEM overlap:** start DIV at cycle 0, drive `stallreq_mem`=1 in cycles 5..7 and 33..34. Required:
  - `stall`=011111 in cycles 5..7, 001111 in the rest of 0..32.
  - `mc_done`=1 in cycles 33..35.
  - `stall`=011111 in cycles 33..34, then 000000 at 35.
  - IDLE at 36.
- **Start blocked by MEM:** `ex_mc_start`=1 and `stallreq_mem`=1 at cycle 0, MEM clears at cycle 2. Required:
  - Acceptance at cycle 2.
  - For MUL, `mc_done` at cycle 6.
- **Reset mid-DIV:** assert `rst` at cycle 10 of a DIV for 1 cycle, with `ex_mc_start` low afterwards. Required: IDLE, `stall`=000000, and no `mc_done` pulse ever appears.
